// File: rtl/alu_pkg.sv
// Shared op-code and FSM state definitions for the bit-serial ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_SUB = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: one result bit and one carry/borrow per step.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_t  op,
  output logic out,
  output logic cout
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    out  = 1'b0;
    cout = 1'b0;
    unique case (op)
      OP_ADD: begin
        out  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_SUB: begin
        out  = a ^ b ^ cin;
        cout = (~a & b) | (~(a ^ b) & cin);
      end
      OP_AND: out = a & b;
      OP_XOR: out = a ^ b;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: latches operands, runs W LSB-first slice steps,
// then presents result/carry/zero with a one-cycle done pulse.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic         cout_o,
  output logic         zero_o
);

  localparam int CW = $clog2(W);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  op_t           r_op;
  logic          r_carry;
  logic          w_out;
  logic          w_cout;
  logic          w_last;
  logic          w_accept;

  assign w_last   = (r_cnt == CW'(W - 1));
  assign w_accept = (r_state == IDLE) && start_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  alu_bit_slice u_slice (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .op   (r_op),
    .out  (w_out),
    .cout (w_cout)
  );

  // Operands shift right so the slice always sees the current bit at index 0;
  // the result fills from the MSB so bit i lands in place after W steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a      <= a_i;
      r_b      <= b_i;
      r_op     <= op_t'(op_i);
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_result <= {w_out, r_result[W-1:1]};
      r_carry  <= w_cout;
      r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE);
  assign result_o = r_result;
  assign cout_o   = r_carry;
  assign zero_o   = (r_result == '0);

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl (W=8) against an arithmetic reference model.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         cout_o;
  logic         zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  serial_alu_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cout_o   (cout_o),
    .zero_o   (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the whole word.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c);
    logic [W:0] t;
    case (op)
      2'b00: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W]; end
      2'b10: begin r = a - b; c = (a < b); end
      2'b01: begin r = a & b; c = 1'b0; end
      default: begin r = a ^ b; c = 1'b0; end
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
    n_checks++; if (result_o !== '0) begin n_fail++; $display("FAIL reset_result got=%h exp=00", result_o); end
    n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout_o); end
    n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", zero_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         ec;
    int           lat;
    model(op, a, b, er, ec);
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0; op_i = 2'($urandom); a_i = W'($urandom); b_i = W'($urandom);
    lat = 1;
    while (done_o !== 1'b1 && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat !== W + 1) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, W + 1); end
    n_checks++; if (result_o !== er) begin n_fail++; $display("FAIL %s_result got=%h exp=%h", name, result_o, er); end
    n_checks++; if (cout_o !== ec) begin n_fail++; $display("FAIL %s_cout got=%b exp=%b", name, cout_o, ec); end
    n_checks++; if (zero_o !== (er == '0)) begin n_fail++; $display("FAIL %s_zero got=%b exp=%b", name, zero_o, (er == '0)); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s_busy_done got=%b exp=1", name, busy_o); end
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL %s_done_width got=%b exp=0", name, done_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_busy_idle got=%b exp=0", name, busy_o); end
    n_checks++; if (result_o !== er) begin n_fail++; $display("FAIL %s_hold got=%h exp=%h", name, result_o, er); end
  endtask

  task automatic test_directed();
    do_op("add_ff_01", 2'b00, 8'hFF, 8'h01);
    do_op("sub_05_07", 2'b10, 8'h05, 8'h07);
    do_op("sub_07_05", 2'b10, 8'h07, 8'h05);
    do_op("and_f0_3c", 2'b01, 8'hF0, 8'h3C);
    do_op("xor_aa_aa", 2'b11, 8'hAA, 8'hAA);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      do_op("random", 2'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] er;
    logic         ec;
    logic [W-1:0] got;
    int           pulses;
    model(2'b00, 8'h3C, 8'h55, er, ec);
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 8'h3C; b_i = 8'h55;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; a_i = W'($urandom); b_i = W'($urandom);
    @(negedge clk);
    start_i = 1'b0;
    pulses = 0; got = '0;
    for (int c = 0; c < 2 * W; c++) begin
      if (done_o === 1'b1) begin pulses++; got = result_o; end
      @(negedge clk);
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_start_pulses got=%0d exp=1", pulses); end
    n_checks++; if (got !== er) begin n_fail++; $display("FAIL ignore_start_result got=%h exp=%h", got, er); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 8'hFF; b_i = 8'hFF;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    n_checks++; if (result_o !== '0) begin n_fail++; $display("FAIL abort_result got=%h exp=00", result_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done_o); end
    n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL abort_cout got=%b exp=0", cout_o); end
    n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL abort_zero got=%b exp=1", zero_o); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_activity got=%0d exp=0", pulses); end
    do_op("add_12_34", 2'b00, 8'h12, 8'h34);
  endtask

  // start_i held high with fresh random operands every cycle: only the
  // operands present in each IDLE cycle (every W+2 cycles) may be used.
  task automatic test_back_to_back();
    logic [W-1:0] q_r[$];
    logic         q_c[$];
    logic [W-1:0] er;
    logic         ec;
    logic         exp_done;
    for (int c = 0; c < 4 * (W + 2); c++) begin
      start_i = 1'b1; op_i = 2'($urandom); a_i = W'($urandom); b_i = W'($urandom);
      if (c % (W + 2) == 0) begin
        model(op_i, a_i, b_i, er, ec);
        q_r.push_back(er);
        q_c.push_back(ec);
      end
      @(negedge clk);
      exp_done = ((c + 1) % (W + 2) == W + 1);
      n_checks++; if (done_o !== exp_done) begin n_fail++; $display("FAIL b2b_done_c%0d got=%b exp=%b", c + 1, done_o, exp_done); end
      if (exp_done && q_r.size() > 0) begin
        er = q_r.pop_front();
        ec = q_c.pop_front();
        n_checks++; if (result_o !== er) begin n_fail++; $display("FAIL b2b_result got=%h exp=%h", result_o, er); end
        n_checks++; if (cout_o !== ec) begin n_fail++; $display("FAIL b2b_cout got=%b exp=%b", cout_o, ec); end
      end
    end
    start_i = 1'b0;
    repeat (W + 3) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_busy got=%b exp=0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
